// File: rtl/line_meta_store.sv
// line_meta_store
//   Line storage with per-line {valid,dirty,accessed} metadata. A valid/ready
//   request port serves READ, strobed WRITE, whole-line FILL and INVALIDATE,
//   answering one cycle after acceptance. A flush engine walks every line and
//   hands each valid+dirty line to the write-back port, then clears its dirty
//   bit.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_*                 request channel (op 0=READ 1=WRITE 2=FILL 3=INVALIDATE)
//   resp_valid/rdata/hit  registered one-cycle response
//   flush_start/busy/done flush control and status
//   wb_valid/ready/index/line  write-back handshake
//   meta_out              {valid,dirty,accessed} per line, line i at [i*3 +: 3]
module line_meta_store #(
  parameter int NUM_LINES      = 3,
  parameter int WORDS_PER_LINE = 16,
  parameter int WORD_WIDTH     = 32,
  localparam int IW = $clog2(NUM_LINES),
  localparam int OW = $clog2(WORDS_PER_LINE),
  localparam int LW = WORDS_PER_LINE * WORD_WIDTH,
  localparam int SW = WORD_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [IW-1:0]          req_index,
  input  logic [OW-1:0]          req_offset,
  input  logic [WORD_WIDTH-1:0]  req_wdata,
  input  logic [SW-1:0]          req_strobe,
  input  logic [LW-1:0]          req_line,
  output logic                   resp_valid,
  output logic [WORD_WIDTH-1:0]  resp_rdata,
  output logic                   resp_hit,
  input  logic                   flush_start,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [IW-1:0]          wb_index,
  output logic [LW-1:0]          wb_line,
  output logic [NUM_LINES*3-1:0] meta_out
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WB, S_DONE} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [NUM_LINES-1:0]    r_valid, r_dirty, r_acc;
  logic [LW-1:0]           r_data [NUM_LINES];
  logic                    r_resp_valid, r_resp_hit;
  logic [WORD_WIDTH-1:0]   r_resp_rdata;
  logic                    r_flush_busy, r_flush_done, r_wb_valid;
  logic [IW-1:0]           r_wb_index;
  logic [LW-1:0]           r_wb_line;

  logic                    w_accept, w_in_range, w_hit, w_last;
  logic [IW-1:0]           w_idx;
  logic [WORD_WIDTH-1:0]   w_old_word, w_wr_word;

  // flush_start wins over a same-cycle request, so it masks ready.
  assign req_ready  = (r_state == S_IDLE) && !flush_start;
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = {1'b0, req_index} < (IW+1)'(NUM_LINES);
  // Out-of-range indices are steered to line 0 for the array lookup; every
  // use is qualified by w_in_range.
  assign w_idx      = w_in_range ? req_index : '0;
  assign w_hit      = w_in_range && r_valid[w_idx];
  assign w_last     = (r_idx == IW'(NUM_LINES - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_old_word = r_data[w_idx][req_offset*WORD_WIDTH +: WORD_WIDTH];
    w_wr_word  = w_old_word;
    for (int b = 0; b < SW; b++) begin
      if (req_strobe[b]) w_wr_word[b*8 +: 8] = req_wdata[b*8 +: 8];
    end
  end

  // NOTE: the line array has no reset; valid bits gate every use of its contents.
  always_ff @(posedge clk) begin
    if (!reset && w_accept && w_in_range) begin
      if (req_op == OP_FILL)
        r_data[w_idx] <= req_line;
      else if (req_op == OP_WRITE && w_hit)
        r_data[w_idx][req_offset*WORD_WIDTH +: WORD_WIDTH] <= w_wr_word;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_acc        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_rdata <= '0;
      r_flush_busy <= 1'b0;
      r_flush_done <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_index   <= '0;
      r_wb_line    <= '0;
    end else begin
      // Request side: only ever accepted in IDLE, so it never races the flush.
      r_resp_valid <= w_accept;
      r_resp_hit   <= w_accept && w_hit;
      r_resp_rdata <= (w_accept && req_op == OP_READ && w_hit) ? w_old_word : '0;
      if (w_accept && w_in_range) begin
        unique case (req_op)
          OP_READ:  if (w_hit) r_acc[w_idx] <= 1'b1;
          OP_WRITE: if (w_hit) begin
                      r_dirty[w_idx] <= 1'b1;
                      r_acc[w_idx]   <= 1'b1;
                    end
          OP_FILL:  begin
                      r_valid[w_idx] <= 1'b1;
                      r_dirty[w_idx] <= 1'b0;
                      r_acc[w_idx]   <= 1'b1;
                    end
          OP_INV:   begin
                      r_valid[w_idx] <= 1'b0;
                      r_dirty[w_idx] <= 1'b0;
                      r_acc[w_idx]   <= 1'b0;
                    end
        endcase
      end

      unique case (r_state)
        S_IDLE: if (flush_start) begin
          r_state      <= S_SCAN;
          r_idx        <= '0;
          r_flush_busy <= 1'b1;
        end
        S_SCAN: begin
          if (r_valid[r_idx] && r_dirty[r_idx]) begin
            r_state    <= S_WB;
            r_wb_valid <= 1'b1;
            r_wb_index <= r_idx;
            r_wb_line  <= r_data[r_idx];
          end else if (w_last) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        S_WB: if (wb_ready) begin
          r_dirty[r_idx] <= 1'b0;
          r_wb_valid     <= 1'b0;
          if (w_last) begin
            r_state      <= S_DONE;
            r_flush_done <= 1'b1;
          end else begin
            r_state <= S_SCAN;
            r_idx   <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_flush_done <= 1'b0;
          r_flush_busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++)
      meta_out[i*3 +: 3] = {r_valid[i], r_dirty[i], r_acc[i]};
  end

  assign resp_valid = r_resp_valid;
  assign resp_hit   = r_resp_hit;
  assign resp_rdata = r_resp_rdata;
  assign flush_busy = r_flush_busy;
  assign flush_done = r_flush_done;
  assign wb_valid   = r_wb_valid;
  assign wb_index   = r_wb_index;
  assign wb_line    = r_wb_line;

endmodule

// File: tb/tb_line_meta_store.sv
module tb_line_meta_store;
  localparam int NL = 3;
  localparam int WPL = 16;
  localparam int WW = 32;
  localparam int IW = $clog2(NL);
  localparam int OW = $clog2(WPL);
  localparam int LW = WPL * WW;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_FILL  = 2'd2;
  localparam logic [1:0] OP_INV   = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_op = '0;
  logic [IW-1:0] req_index = '0;
  logic [OW-1:0] req_offset = '0;
  logic [WW-1:0] req_wdata = '0;
  logic [WW/8-1:0] req_strobe = '0;
  logic [LW-1:0] req_line = '0;
  logic resp_valid, resp_hit;
  logic [WW-1:0] resp_rdata;
  logic flush_start = 1'b0;
  logic flush_busy, flush_done;
  logic wb_valid;
  logic wb_ready = 1'b0;
  logic [IW-1:0] wb_index;
  logic [LW-1:0] wb_line;
  logic [NL*3-1:0] meta_out;

  line_meta_store #(.NUM_LINES(NL), .WORDS_PER_LINE(WPL), .WORD_WIDTH(WW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_index(req_index), .req_offset(req_offset), .req_wdata(req_wdata),
    .req_strobe(req_strobe), .req_line(req_line),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .flush_start(flush_start), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_index(wb_index),
    .wb_line(wb_line), .meta_out(meta_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays of words and metadata flags.
  logic [WW-1:0] m_data [NL][WPL];
  bit m_valid [NL];
  bit m_dirty [NL];
  bit m_acc [NL];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] line_of(input int l);
    logic [LW-1:0] v;
    for (int k = 0; k < WPL; k++) v[k*WW +: WW] = m_data[l][k];
    return v;
  endfunction

  function automatic logic [NL*3-1:0] model_meta();
    logic [NL*3-1:0] v;
    for (int i = 0; i < NL; i++) v[i*3 +: 3] = {m_valid[i], m_dirty[i], m_acc[i]};
    return v;
  endfunction

  task automatic model_clear_meta();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_acc[i] = 0;
    end
  endtask

  // Called at a negedge with the flush engine idle; returns at the next negedge
  // after checking the response.
  task automatic do_req(input logic [1:0] op, input int idx, input int off,
                        input logic [WW-1:0] wd, input logic [WW/8-1:0] st,
                        input logic [LW-1:0] ln);
    bit in_rng = (idx < NL);
    bit exp_hit = in_rng && m_valid[idx];
    logic [WW-1:0] exp_rd = '0;
    req_op = op;
    req_index = IW'(idx);
    req_offset = OW'(off);
    req_wdata = wd;
    req_strobe = st;
    req_line = ln;
    req_valid = 1'b1;
    #1 check("req_ready", req_ready, 1);
    if (in_rng) begin
      case (op)
        OP_READ: if (exp_hit) begin
          exp_rd = m_data[idx][off];
          m_acc[idx] = 1;
        end
        OP_WRITE: if (exp_hit) begin
          for (int b = 0; b < WW/8; b++)
            if (st[b]) m_data[idx][off][b*8 +: 8] = wd[b*8 +: 8];
          m_dirty[idx] = 1; m_acc[idx] = 1;
        end
        OP_FILL: begin
          for (int k = 0; k < WPL; k++) m_data[idx][k] = ln[k*WW +: WW];
          m_valid[idx] = 1; m_dirty[idx] = 0; m_acc[idx] = 1;
        end
        default: begin
          m_valid[idx] = 0; m_dirty[idx] = 0; m_acc[idx] = 0;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("resp_valid", resp_valid, 1);
    check("resp_hit", resp_hit, exp_hit);
    check("resp_rdata", resp_rdata, exp_rd);
    check("meta_out", meta_out, model_meta());
  endtask

  // Runs a complete flush from a negedge. stall_fixed >= 0 holds wb_ready low
  // that many cycles per line; otherwise stalls are random 0..3.
  task automatic run_flush(input int stall_fixed, input bit with_req);
    int q[$];
    int stall, cyc;
    bit done, hs;
    for (int i = 0; i < NL; i++) if (m_valid[i] && m_dirty[i]) q.push_back(i);
    flush_start = 1'b1;
    if (with_req) begin
      req_valid = 1'b1; req_op = OP_READ; req_index = '0; req_offset = '0;
    end
    #1 check("prio_ready", req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    flush_start = 1'b0;
    req_valid = 1'b0;
    check("prio_no_resp", resp_valid, 0);
    stall = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(3, 0));
    done = 0;
    cyc = 0;
    while (!done && cyc < 300) begin
      check("flush_busy", flush_busy, 1);
      if (flush_done) begin
        done = 1;
      end else begin
        hs = 0;
        if (wb_valid) begin
          if (q.size() == 0) begin
            check("wb_unexpected", wb_valid, 0);
          end else begin
            check("wb_index", wb_index, q[0]);
            check("wb_line", wb_line, line_of(q[0]));
            if (stall == 0) begin
              wb_ready = 1'b1; hs = 1;
            end else begin
              stall--;
            end
          end
        end
        @(posedge clk);
        #1 wb_ready = 1'b0;
        if (hs) begin
          m_dirty[q[0]] = 0;
          void'(q.pop_front());
          stall = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(3, 0));
        end
        @(negedge clk);
        cyc++;
      end
    end
    check("flush_done_seen", done, 1);
    check("flush_all_written", q.size(), 0);
    @(negedge clk);
    check("flush_done_pulse", flush_done, 0);
    check("flush_busy_end", flush_busy, 0);
    check("flush_meta", meta_out, model_meta());
  endtask

  initial begin
    logic [LW-1:0] ln;
    int waited;
    model_clear_meta();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    check("rst_meta", meta_out, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_index", wb_index, 0);
    check("rst_wb_line", wb_line, 0);
    check("rst_rdata", resp_rdata, 0);
    do_req(OP_READ, 1, 0, '0, '0, '0);

    // Fill lines with word k = 3k+l+1.
    for (int l = 0; l < NL; l++) begin
      for (int k = 0; k < WPL; k++) ln[k*WW +: WW] = WW'(3*k + l + 1);
      do_req(OP_FILL, l, 0, '0, '0, ln);
    end
    do_req(OP_READ, 2, 5, '0, '0, '0);
    check("fill_read_word", resp_rdata, 32'h12);

    // Strobed write and immediate read-back.
    do_req(OP_WRITE, 1, 0, 32'hDEADBEEF, 4'b0011, '0);
    do_req(OP_READ, 1, 0, '0, '0, '0);
    check("strobe_readback", resp_rdata, 32'h0000BEEF);
    // The idle cycle after a response carries no response.
    @(negedge clk);
    check("resp_pulse", resp_valid, 0);

    // Dirty only lines 0 and 2, then flush with 3-cycle stalls and a
    // colliding request.
    do_req(OP_FILL, 1, 0, '0, '0, line_of(1));
    do_req(OP_WRITE, 0, 3, 32'h11223344, 4'b1111, '0);
    do_req(OP_WRITE, 2, 7, 32'hA5A5A5A5, 4'b1100, '0);
    run_flush(3, 1);
    do_req(OP_READ, 2, 7, '0, '0, '0);

    // Randomized traffic with periodic flushes.
    for (int n = 0; n < 240; n++) begin
      for (int k = 0; k < WPL; k++) ln[k*WW +: WW] = $urandom;
      do_req(2'($urandom_range(3, 0)), int'($urandom_range(NL, 0)),
             int'($urandom_range(WPL - 1, 0)), $urandom, 4'($urandom), ln);
      if (n % 40 == 39) run_flush(-1, n[0]);
    end

    // Reset while a write-back is pending.
    do_req(OP_FILL, 0, 0, '0, '0, line_of(0));
    do_req(OP_WRITE, 0, 1, 32'hCAFEF00D, 4'b1111, '0);
    flush_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush_start = 1'b0;
    waited = 0;
    while (!wb_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("mid_wb_valid", wb_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear_meta();
    check("mid_rst_wb_valid", wb_valid, 0);
    check("mid_rst_meta", meta_out, 0);
    check("mid_rst_busy", flush_busy, 0);
    check("mid_rst_resp", resp_valid, 0);

    // Out-of-range index behaves as a miss and changes nothing.
    do_req(OP_FILL, 1, 0, '0, '0, line_of(1));
    do_req(OP_INV, 3, 0, '0, '0, '0);
    do_req(OP_FILL, 3, 0, '0, '0, line_of(1));
    do_req(OP_WRITE, 3, 0, 32'hFFFFFFFF, 4'hF, '0);
    do_req(OP_READ, 1, 4, '0, '0, '0);
    do_req(OP_INV, 1, 0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
